// File: rtl/matrix_inverse_2x2_seq.sv
// matrix_inverse_2x2_seq
// Sequential 2x2 signed fixed-point matrix inverter for the Kalman gain path.
// It accepts S = [[a00,a01],[a10,a11]] and returns inv(S) = adj(S) / det(S).
// 1/|det| is computed once with a serial restoring divider, and the four
// adjugate elements are then scaled through a single shared multiplier.
// Every element is Q(INT_DIGITS).(FRAC) two's complement.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clk_en          low freezes every register in the block
//   in_valid/ready  input handshake for a00..a11
//   out_valid/ready output handshake for r00..r11, singular and overflow
//   singular        det == 0, so the result is forced to zero
//   overflow        at least one result element was saturated
module matrix_inverse_2x2_seq #(
  parameter int WIDTH      = 16,
  parameter int INT_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a00,
  input  logic signed [WIDTH-1:0] a01,
  input  logic signed [WIDTH-1:0] a10,
  input  logic signed [WIDTH-1:0] a11,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] r00,
  output logic signed [WIDTH-1:0] r01,
  output logic signed [WIDTH-1:0] r10,
  output logic signed [WIDTH-1:0] r11,
  output logic                    singular,
  output logic                    overflow
);

  localparam int FRAC  = WIDTH - INT_DIGITS;
  localparam int DIVW  = 3 * FRAC + 1;
  localparam int DETW  = 2 * WIDTH + 1;
  localparam int MAGW  = 2 * WIDTH;
  localparam int REMW  = MAGW + 1;
  localparam int CNTW  = $clog2(DIVW + 1);
  localparam int PRODW = WIDTH + 1 + DIVW;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, DET, CHECK, DIV, MUL, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  a00_q, a01_q, a10_q, a11_q;
  logic signed [WIDTH-1:0]  a00_d, a01_d, a10_d, a11_d;
  logic signed [DETW-1:0]   det_q, det_d;
  logic                     sdet_q, sdet_d;
  logic [MAGW-1:0]          mag_q, mag_d;
  logic [REMW-1:0]          rem_q, rem_d;
  logic [DIVW-1:0]          quo_q, quo_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [1:0]               elem_q, elem_d;
  logic signed [WIDTH-1:0]  r00_q, r01_q, r10_q, r11_q;
  logic signed [WIDTH-1:0]  r00_d, r01_d, r10_d, r11_d;
  logic                     singular_q, singular_d;
  logic                     overflow_q, overflow_d;

  logic [DETW-1:0]          det_abs;
  logic [REMW-1:0]          rem_shift;
  logic                     div_bit;
  logic signed [WIDTH-1:0]  adj_src;
  logic                     adj_neg;
  logic [WIDTH:0]           src_ext;
  logic [WIDTH:0]           src_mag;
  logic [PRODW-1:0]         prod;
  logic [PRODW-1:0]         p_full;
  logic                     sat;
  logic [WIDTH-1:0]         p_mag;
  logic [WIDTH-1:0]         res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r00       = r00_q;
  assign r01       = r01_q;
  assign r10       = r10_q;
  assign r11       = r11_q;
  assign singular  = singular_q;
  assign overflow  = overflow_q;

  assign det_abs = det_q[DETW-1] ? -det_q : det_q;

  // The dividend 2^(3*FRAC) has a single set bit, which is the first bit
  // shifted in while the counter still holds its load value.
  assign div_bit   = (cnt_q == CNTW'(DIVW));
  assign rem_shift = {rem_q[REMW-2:0], div_bit};

  // Shared multiplier datapath. adj_neg is the sign of the adjugate entry
  // itself; the negated entries are negative when the source is positive.
  always_comb begin
    adj_src = a11_q;
    adj_neg = a11_q[WIDTH-1];
    case (elem_q)
      2'd0: begin adj_src = a11_q; adj_neg = a11_q[WIDTH-1]; end
      2'd1: begin adj_src = a01_q; adj_neg = (a01_q != '0) && !a01_q[WIDTH-1]; end
      2'd2: begin adj_src = a10_q; adj_neg = (a10_q != '0) && !a10_q[WIDTH-1]; end
      default: begin adj_src = a00_q; adj_neg = a00_q[WIDTH-1]; end
    endcase
  end

  // The magnitude is taken one bit wider so that -2^(WIDTH-1) survives.
  // Negating a zero magnitude yields zero, so a zero result never turns
  // negative.
  always_comb begin
    src_ext = {adj_src[WIDTH-1], adj_src};
    src_mag = src_ext[WIDTH] ? -src_ext : src_ext;
    prod    = PRODW'(src_mag) * PRODW'(quo_q);
    p_full  = prod >> FRAC;
    sat     = (p_full > PRODW'(MAXV));
    p_mag   = sat ? MAXV : p_full[WIDTH-1:0];
    res     = (adj_neg ^ sdet_q) ? -p_mag : p_mag;
  end

  always_comb begin
    state_d    = state_q;
    a00_d      = a00_q;
    a01_d      = a01_q;
    a10_d      = a10_q;
    a11_d      = a11_q;
    det_d      = det_q;
    sdet_d     = sdet_q;
    mag_d      = mag_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    elem_d     = elem_q;
    r00_d      = r00_q;
    r01_d      = r01_q;
    r10_d      = r10_q;
    r11_d      = r11_q;
    singular_d = singular_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a00_d   = a00;
          a01_d   = a01;
          a10_d   = a10;
          a11_d   = a11;
          state_d = DET;
        end
      end

      DET: begin
        det_d   = DETW'(a00_q) * DETW'(a11_q) - DETW'(a01_q) * DETW'(a10_q);
        state_d = CHECK;
      end

      CHECK: begin
        if (det_q == '0) begin
          r00_d      = '0;
          r01_d      = '0;
          r10_d      = '0;
          r11_d      = '0;
          singular_d = 1'b1;
          overflow_d = 1'b0;
          state_d    = DONE;
        end else begin
          sdet_d     = det_q[DETW-1];
          mag_d      = det_abs[MAGW-1:0];
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CNTW'(DIVW);
          elem_d     = 2'd0;
          singular_d = 1'b0;
          overflow_d = 1'b0;
          state_d    = DIV;
        end
      end

      DIV: begin
        if (rem_shift >= {1'b0, mag_q}) begin
          rem_d = rem_shift - {1'b0, mag_q};
          quo_d = {quo_q[DIVW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[DIVW-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = MUL;
        end
      end

      MUL: begin
        case (elem_q)
          2'd0:    r00_d = res;
          2'd1:    r01_d = res;
          2'd2:    r10_d = res;
          default: r11_d = res;
        endcase
        overflow_d = overflow_q | sat;
        elem_d     = elem_q + 2'd1;
        if (elem_q == 2'd3) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a00_q      <= '0;
      a01_q      <= '0;
      a10_q      <= '0;
      a11_q      <= '0;
      det_q      <= '0;
      sdet_q     <= 1'b0;
      mag_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      elem_q     <= '0;
      r00_q      <= '0;
      r01_q      <= '0;
      r10_q      <= '0;
      r11_q      <= '0;
      singular_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      a00_q      <= a00_d;
      a01_q      <= a01_d;
      a10_q      <= a10_d;
      a11_q      <= a11_d;
      det_q      <= det_d;
      sdet_q     <= sdet_d;
      mag_q      <= mag_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      elem_q     <= elem_d;
      r00_q      <= r00_d;
      r01_q      <= r01_d;
      r10_q      <= r10_d;
      r11_q      <= r11_d;
      singular_q <= singular_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
